// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two FIFO; frames are start, DATA_BITS LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN to append an even-parity bit after the payload.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int DEPTH_LOG2   = 10,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic [DATA_BITS-1:0]  din,
    input  logic                  vdin,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  busy,
    output logic                  dout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int BW    = $clog2(DATA_BITS);
    localparam logic [CW-1:0]       CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]       BIT_MAX   = BW'(DATA_BITS - 1);
    localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic                STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                  r_state;
    logic [CW-1:0]           r_baud;
    logic [BW-1:0]           r_bit;
    logic                    r_stop;
    logic                    r_dout;
    logic [DATA_BITS-1:0]    r_shift;
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_level;
    logic                    r_overflow;
    logic [DATA_BITS-1:0]    r_mem [DEPTH];
`ifdef UART_TX_PARITY_EN
    logic                    r_parity;
`endif

    logic                    w_tick;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_wr;
    logic                    w_pop;
    logic                    w_shift;
    logic [DATA_BITS-1:0]    w_head;

    assign w_tick  = (r_baud == CNT_MAX);
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);
    assign w_wr    = vdin & ~w_full;
    assign w_head  = r_mem[r_rd_ptr];
    // A frame is loaded either from idle or at the end of the last stop bit (back-to-back).
    assign w_pop   = ~w_empty & ((r_state == S_IDLE) |
                                 ((r_state == S_STOP) & w_tick & (r_stop == STOP_LAST)));
    assign w_shift = w_tick & ((r_state == S_START) | (r_state == S_DATA));

    assign full     = w_full;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE) | ~w_empty;
    assign dout     = r_dout;

    always_ff @(posedge clk_100MHz) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (vdin && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (w_pop) begin
            r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
        end else if (w_shift) begin
            r_shift <= r_shift >> 1;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_dout  <= 1'b1;
        end else begin
            if (r_state == S_IDLE || w_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_dout <= 1'b1;
                    if (w_pop) begin
                        r_dout  <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_dout  <= r_shift[0];
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit == BIT_MAX) begin
`ifdef UART_TX_PARITY_EN
                            r_dout  <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_dout  <= 1'b1;
                            r_stop  <= 1'b0;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_dout <= r_shift[0];
                            r_bit  <= r_bit + BW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_dout  <= 1'b1;
                        r_stop  <= 1'b0;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        if (r_stop == STOP_LAST) begin
                            if (w_pop) begin
                                r_dout  <= 1'b0;
                                r_state <= S_START;
                            end else begin
                                r_dout  <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_stop <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_dout  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with 16 clocks per bit and a 4-entry FIFO.
module tb_uart_tx_fifo;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       vdin;
    logic       full;
    logic [2:0] level;
    logic       overflow;
    logic       busy;
    logic       dout;

    int n_vec  = 0;
    int n_fail = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .DEPTH_LOG2   (2),
        .STOP_BITS    (1)
    ) dut (
        .clk_100MHz (clk),
        .reset      (rst),
        .din        (din),
        .vdin       (vdin),
        .full       (full),
        .level      (level),
        .overflow   (overflow),
        .busy       (busy),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;  // bit i = i-th bit on the line, start first
        logic       par;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [10:0] exp_frame(input logic [9:0] frame, input logic par);
`ifdef UART_TX_PARITY_EN
        return {1'b1, par, frame[8:0]};
`else
        return {1'b0, frame};
`endif
    endfunction

    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        return exp_frame(f, ^d);
    endfunction

    // Called one cycle (plus skip) after the start bit appeared; samples mid-bit.
    task automatic rx_frame(input int skip, output logic [10:0] bits);
        bits = '0;
        repeat (CPB/2 - skip) tick();
        bits[0] = dout;
        for (int k = 1; k < NB; k++) begin
            repeat (CPB) tick();
            bits[k] = dout;
        end
    endtask

    task automatic wait_fall(input string name, output int n);
        n = 0;
        while (dout !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check(name, dout, 0);
    endtask

    task automatic tail_check(input string name);
        repeat (CPB/2 - 1) tick();
        check({name, "_busy_hi"}, busy, 1);
        tick();
        check({name, "_busy_lo"}, busy, 0);
        check({name, "_idle_hi"}, dout, 1);
    endtask

    logic [10:0] bits;
    int          n;
    int          zeros;
    logic [7:0]  ovf_data [6];
    int          max_lvl;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h55, 10'h2AA, 1'b0};
        vecs[1] = '{8'hA3, 10'h346, 1'b0};
        vecs[2] = '{8'h0F, 10'h21E, 1'b0};
        vecs[3] = '{8'h00, 10'h200, 1'b0};
        vecs[4] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[5] = '{8'h07, 10'h20E, 1'b1};
        vecs[6] = '{8'h03, 10'h206, 1'b0};
        vecs[7] = '{8'h80, 10'h300, 1'b1};

        rst  = 1'b1;
        vdin = 1'b0;
        din  = 8'h00;
        repeat (3) tick();
        check("rst_dout", dout, 1);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Single frames from an idle, empty FIFO
        for (int i = 0; i < 8; i++) begin
            vdin = 1'b1;
            din  = vecs[i].d;
            tick();
            vdin = 1'b0;
            check("lat1_dout", dout, 1);
            check("lat1_level", level, 1);
            tick();
            check("lat2_dout", dout, 0);
            check("lat2_level", level, 0);
            rx_frame(0, bits);
            check($sformatf("frame_%02h", vecs[i].d), bits, exp_frame(vecs[i].frame, vecs[i].par));
            tail_check("single");
            repeat (5) tick();
        end

        // Back-to-back: A3 then 0F on consecutive cycles
        vdin = 1'b1;
        din  = 8'hA3;
        tick();
        check("b2b_lvl1", level, 1);
        din = 8'h0F;
        tick();
        vdin = 1'b0;
        check("b2b_lvl2", level, 1);
        check("b2b_start1", dout, 0);
        rx_frame(0, bits);
        check("b2b_frame1", bits, exp_frame(vecs[1].frame, vecs[1].par));
        wait_fall("b2b_start2", n);
        check("b2b_gap", n, CPB/2);
        check("b2b_lvl3", level, 0);
        rx_frame(0, bits);
        check("b2b_frame2", bits, exp_frame(vecs[2].frame, vecs[2].par));
        tail_check("b2b");
        repeat (5) tick();

        // Full and overflow while a frame is on the line
        ovf_data = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76};
        vdin = 1'b1;
        din  = 8'h11;
        tick();
        vdin = 1'b0;
        tick();
        check("ovf_start", dout, 0);
        for (int j = 0; j < 6; j++) begin
            vdin = 1'b1;
            din  = ovf_data[j];
            tick();
            check($sformatf("ovf_lvl%0d", j), level, (j < 3) ? j + 1 : 4);
            check($sformatf("ovf_full%0d", j), full, (j >= 3) ? 1 : 0);
            check($sformatf("ovf_flag%0d", j), overflow, (j >= 4) ? 1 : 0);
        end
        vdin = 1'b0;
        rx_frame(6, bits);
        check("ovf_frame0", bits, model_frame(8'h11));
        for (int j = 0; j < 4; j++) begin
            wait_fall("ovf_start_n", n);
            check("ovf_gap", n, CPB/2);
            rx_frame(0, bits);
            check($sformatf("ovf_frame_%02h", ovf_data[j]), bits, model_frame(ovf_data[j]));
        end
        tail_check("ovf");
        zeros = 0;
        repeat (200) begin
            tick();
            if (dout !== 1'b1) zeros++;
        end
        check("ovf_no_extra", zeros, 0);
        check("ovf_sticky", overflow, 1);
        check("ovf_lvl_end", level, 0);

        // Reset during bit 4 of 0xFF with three bytes queued
        vdin = 1'b1;
        din  = 8'hFF;
        tick();
        vdin = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            vdin = 1'b1;
            din  = 8'hC0 + 8'(j);
            tick();
        end
        vdin = 1'b0;
        check("rmf_queued", level, 3);
        repeat (67) tick();
        check("rmf_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        check("rmf_dout", dout, 1);
        check("rmf_level", level, 0);
        check("rmf_busy", busy, 0);
        check("rmf_full", full, 0);
        check("rmf_ovf", overflow, 0);
        tick();
        tick();
        rst = 1'b0;
        zeros = 0;
        repeat (300) begin
            tick();
            if (dout !== 1'b1 || busy !== 1'b0) zeros++;
        end
        check("rmf_quiet", zeros, 0);

        // Pointer wrap: ten bytes streamed, never more than three queued
        max_lvl = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int guard;
                    guard = 0;
                    while (level >= 3 && guard < 3000) begin
                        tick();
                        guard++;
                    end
                    vdin = 1'b1;
                    din  = 8'(i);
                    tick();
                    vdin = 1'b0;
                    if (int'(level) > max_lvl) max_lvl = int'(level);
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    int nn;
                    logic [10:0] rb;
                    wait_fall("wrap_start", nn);
                    rx_frame(0, rb);
                    check($sformatf("wrap_frame_%0d", i), rb, model_frame(8'(i)));
                end
            end
        join
        check("wrap_max_lvl", (max_lvl <= 3) ? 1 : 0, 1);
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check("wrap_busy_end", busy, 0);
        check("wrap_lvl_end", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
